// File: rtl/uart_tx_engine.sv
// UART transmit serializer: start bit, LSB-first data, optional parity, then 1 or 2 stop bits.
// Bit boundaries follow the rising edges of baud_clk, which is synchronous to clock.
module uart_tx_engine #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 baud_clk,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int               CNT_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_baud_clk_q;
    logic                 w_baud_tick;
    logic                 w_accept;

    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic                 r_par;
    logic                 r_parity_en;
    logic                 r_two_stop;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [CNT_W-1:0]     w_bit_cnt_nxt;
    logic                 r_stop_cnt;
    logic                 w_stop_cnt_nxt;
    logic                 r_tx_serial;
    logic                 w_tx_serial_nxt;
    logic                 r_tx_done;
    logic                 w_tx_done_nxt;

    assign w_baud_tick = baud_clk & ~r_baud_clk_q;
    assign w_accept    = tx_valid & tx_ready;

    // The tx_done cycle is already IDLE, but a new word is held off until the next cycle.
    assign tx_ready  = (r_state == IDLE) && !r_tx_done;
    assign tx_busy   = (r_state != IDLE);
    assign tx_serial = r_tx_serial;
    assign tx_done   = r_tx_done;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)    w_state_nxt = ARMED;
            ARMED:   if (w_baud_tick) w_state_nxt = START;
            START:   if (w_baud_tick) w_state_nxt = DATA;
            DATA: begin
                if (w_baud_tick && (r_bit_cnt >= LAST_BIT)) begin
                    w_state_nxt = r_parity_en ? PARITY : STOP;
                end
            end
            PARITY:  if (w_baud_tick) w_state_nxt = STOP;
            STOP: begin
                if (w_baud_tick && !(r_two_stop && !r_stop_cnt)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of the registered datapath, committed on the same edge as the state change.
    always_comb begin
        w_tx_serial_nxt = r_tx_serial;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_stop_cnt_nxt  = r_stop_cnt;
        w_shift_nxt     = r_shift;
        w_tx_done_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                w_tx_serial_nxt = 1'b1;
                if (w_accept) w_shift_nxt = tx_data;
            end
            ARMED: begin
                if (w_baud_tick) w_tx_serial_nxt = 1'b0;
            end
            START: begin
                if (w_baud_tick) begin
                    w_tx_serial_nxt = r_shift[0];
                    w_shift_nxt     = r_shift >> 1;
                    w_bit_cnt_nxt   = '0;
                end
            end
            DATA: begin
                if (w_baud_tick) begin
                    if (r_bit_cnt < LAST_BIT) begin
                        w_bit_cnt_nxt   = r_bit_cnt + 1'b1;
                        w_tx_serial_nxt = r_shift[0];
                        w_shift_nxt     = r_shift >> 1;
                    end else if (r_parity_en) begin
                        w_tx_serial_nxt = r_par;
                    end else begin
                        w_tx_serial_nxt = 1'b1;
                        w_stop_cnt_nxt  = 1'b0;
                    end
                end
            end
            PARITY: begin
                if (w_baud_tick) begin
                    w_tx_serial_nxt = 1'b1;
                    w_stop_cnt_nxt  = 1'b0;
                end
            end
            STOP: begin
                if (w_baud_tick) begin
                    if (r_two_stop && !r_stop_cnt) begin
                        w_stop_cnt_nxt = 1'b1;
                    end else begin
                        w_tx_done_nxt = 1'b1;
                    end
                end
            end
            default: w_tx_serial_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_baud_clk_q <= 1'b0;
            r_tx_serial  <= 1'b1;
            r_tx_done    <= 1'b0;
            r_bit_cnt    <= '0;
            r_stop_cnt   <= 1'b0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_parity_en  <= 1'b0;
            r_two_stop   <= 1'b0;
        end else begin
            r_baud_clk_q <= baud_clk;
            r_tx_serial  <= w_tx_serial_nxt;
            r_tx_done    <= w_tx_done_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_stop_cnt   <= w_stop_cnt_nxt;
            r_shift      <= w_shift_nxt;
            // Frame options are frozen at accept so later input changes cannot disturb the frame.
            if (w_accept) begin
                r_par       <= (^tx_data) ^ parity_odd;
                r_parity_en <= parity_en;
                r_two_stop  <= two_stop;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: directed frames plus random frames, each line bit
// compared against a frame list built from the word and its options.
module tb_uart_tx_engine;

    localparam int DB       = 8;
    localparam int BIT_CLKS = 16;

    logic          clock      = 1'b0;
    logic          reset_n    = 1'b0;
    logic          baud_clk;
    logic [DB-1:0] tx_data    = '0;
    logic          tx_valid   = 1'b0;
    logic          parity_en  = 1'b0;
    logic          parity_odd = 1'b0;
    logic          two_stop   = 1'b0;
    logic          tx_ready;
    logic          tx_serial;
    logic          tx_busy;
    logic          tx_done;

    int n_vec    = 0;
    int n_fail   = 0;
    int baud_cnt = BIT_CLKS - 1;
    bit exp_bits[$];

    uart_tx_engine #(.DATA_BITS(DB)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .baud_clk   (baud_clk),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .parity_en  (parity_en),
        .parity_odd (parity_odd),
        .two_stop   (two_stop),
        .tx_serial  (tx_serial),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clock = ~clock;

    // baud_clk is high for 8 clocks and low for 8; it rises on the negedge where baud_cnt becomes 0.
    always @(negedge clock) begin
        baud_cnt <= (baud_cnt + 1) % BIT_CLKS;
        baud_clk <= (((baud_cnt + 1) % BIT_CLKS) < (BIT_CLKS / 2));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start, data LSB first, optional parity making the ones count even/odd, stops.
    task automatic build_frame(input logic [DB-1:0] d, input bit pe, input bit po, input bit ts);
        int ones;
        ones = 0;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < DB; i++) begin
            exp_bits.push_back(d[i]);
            if (d[i]) ones++;
        end
        if (pe) exp_bits.push_back(po ? ((ones % 2) == 0) : ((ones % 2) == 1));
        exp_bits.push_back(1'b1);
        if (ts) exp_bits.push_back(1'b1);
    endtask

    // Presents a word and returns at the negedge just after the accepting posedge.
    task automatic offer(input string tag, input logic [DB-1:0] d, input bit pe, input bit po,
                         input bit ts, input bit hold);
        bit ok;
        int waited;
        ok     = 1'b0;
        waited = 0;
        @(negedge clock);
        tx_data    = d;
        parity_en  = pe;
        parity_odd = po;
        two_stop   = ts;
        tx_valid   = 1'b1;
        while (!ok && waited < 4 * BIT_CLKS) begin
            if (tx_ready === 1'b1) begin
                ok = 1'b1;
                @(posedge clock);
            end else begin
                @(negedge clock);
                waited++;
            end
        end
        check({tag, "_accept"}, ok, 1);
        @(negedge clock);
        if (!hold) tx_valid = 1'b0;
        check({tag, "_ready_low"}, tx_ready, 0);
        check({tag, "_busy"}, tx_busy, 1);
    endtask

    // Called at the negedge after accept; returns at the negedge after the tx_done cycle.
    task automatic check_frame(input string tag, input logic [DB-1:0] d, input bit pe,
                               input bit po, input bit ts, input bit mutate);
        bit found;
        int waited;
        int bad;
        build_frame(d, pe, po, ts);
        found  = 1'b0;
        waited = 0;
        while (!found && waited < 2 * BIT_CLKS + 2) begin
            if (tx_serial === 1'b0) begin
                found = 1'b1;
            end else begin
                @(negedge clock);
                waited++;
            end
        end
        check({tag, "_start_seen"}, found, 1);
        check({tag, "_start_on_tick"}, baud_cnt, 0);
        for (int b = 0; b < exp_bits.size(); b++) begin
            bad = 0;
            for (int s = 0; s < BIT_CLKS; s++) begin
                if (tx_serial !== exp_bits[b] || tx_done !== 1'b0 || tx_busy !== 1'b1) bad++;
                if (mutate && b == 3 && s == 0) begin
                    tx_data    = ~d;
                    parity_en  = ~pe;
                    parity_odd = ~po;
                    two_stop   = ~ts;
                end
                @(negedge clock);
            end
            check($sformatf("%s_bit%0d_exp%0d_bad_samples", tag, b, exp_bits[b]), bad, 0);
        end
        check({tag, "_done_pulse"}, tx_done, 1);
        check({tag, "_done_line_idle"}, tx_serial, 1);
        check({tag, "_ready_in_done"}, tx_ready, 0);
        @(negedge clock);
        check({tag, "_done_one_cycle"}, tx_done, 0);
        check({tag, "_ready_after_done"}, tx_ready, 1);
        check({tag, "_idle_after_done"}, tx_busy, 0);
    endtask

    initial begin
        int            bad;
        int            dones;
        logic [DB-1:0] rd;
        bit            rpe, rpo, rts, rmut;

        // Reset state, then a long idle stretch.
        repeat (3) @(negedge clock);
        check("rst_serial", tx_serial, 1);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", tx_busy, 0);
        check("rst_done", tx_done, 0);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (tx_serial !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad++;
        end
        check("idle_100_bad_cycles", bad, 0);

        // 8N1, parity even/odd, two stop bits with inputs disturbed mid-frame.
        offer("f55", 8'h55, 0, 0, 0, 0);
        check_frame("f55", 8'h55, 0, 0, 0, 0);
        offer("fA7e", 8'hA7, 1, 0, 0, 0);
        check_frame("fA7e", 8'hA7, 1, 0, 0, 0);
        offer("fA7o", 8'hA7, 1, 1, 0, 0);
        check_frame("fA7o", 8'hA7, 1, 1, 0, 0);
        offer("f3C", 8'h3C, 0, 0, 1, 0);
        check_frame("f3C", 8'h3C, 0, 0, 1, 1);

        // tx_valid held: two back-to-back frames, tx_ready high for one cycle between them.
        offer("h01", 8'h01, 0, 0, 0, 1);
        tx_data = 8'h80;
        check_frame("h01", 8'h01, 0, 0, 0, 0);
        @(negedge clock);
        check("h_ready_one_cycle", tx_ready, 0);
        check("h_second_busy", tx_busy, 1);
        tx_valid = 1'b0;
        check_frame("h80", 8'h80, 0, 0, 0, 0);
        bad = 0;
        for (int i = 0; i < 3 * BIT_CLKS; i++) begin
            @(negedge clock);
            if (tx_busy !== 1'b0 || tx_serial !== 1'b1) bad++;
        end
        check("h_no_third_frame", bad, 0);

        // Reset during data bit 3 aborts the frame.
        offer("rA5", 8'hA5, 0, 0, 0, 0);
        bad = 0;
        while (tx_serial !== 1'b0 && bad < 2 * BIT_CLKS + 2) begin
            @(negedge clock);
            bad++;
        end
        repeat (4 * BIT_CLKS + 6) @(negedge clock);
        check("rA5_bit3_low", tx_serial, 0);
        reset_n = 1'b0;
        #1;
        check("rA5_abort_serial", tx_serial, 1);
        check("rA5_abort_busy", tx_busy, 0);
        check("rA5_abort_done", tx_done, 0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        dones = 0;
        bad   = 0;
        for (int i = 0; i < 20 * BIT_CLKS; i++) begin
            @(negedge clock);
            if (tx_done !== 1'b0) dones++;
            if (tx_serial !== 1'b1) bad++;
        end
        check("rA5_no_done_after_abort", dones, 0);
        check("rA5_line_idle_after_abort", bad, 0);
        offer("f0F", 8'h0F, 0, 0, 0, 0);
        check_frame("f0F", 8'h0F, 0, 0, 0, 0);

        // Random words and frame options.
        for (int n = 0; n < 8; n++) begin
            rd   = DB'($urandom_range(0, (1 << DB) - 1));
            rpe  = 1'($urandom_range(0, 1));
            rpo  = 1'($urandom_range(0, 1));
            rts  = 1'($urandom_range(0, 1));
            rmut = 1'($urandom_range(0, 1));
            offer($sformatf("rnd%0d", n), rd, rpe, rpo, rts, 0);
            check_frame($sformatf("rnd%0d", n), rd, rpe, rpo, rts, rmut);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
